// File: rtl/mul_share_arb_if.sv
// Bundle of the requester-side and multiplier-core-side signals of mul_share_arb.
// The arbiter uses the slave view; clients plus the multiplier core use the master view.
interface mul_share_arb_if #(
    parameter int NREQ = 4
) ();
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ack;

    logic              mul_start;
    logic [7:0]        mul_a;
    logic [7:0]        mul_b;
    logic              mul_done;
    logic [15:0]       mul_product;

    logic              res_valid;
    logic [IDW-1:0]    res_id;
    logic [15:0]       res_product;
    logic              res_err;
    logic              busy;

    modport slave (
        input  req, req_a, req_b, mul_done, mul_product,
        output req_ack, mul_start, mul_a, mul_b,
               res_valid, res_id, res_product, res_err, busy
    );

    modport master (
        output req, req_a, req_b, mul_done, mul_product,
        input  req_ack, mul_start, mul_a, mul_b,
               res_valid, res_id, res_product, res_err, busy
    );
endinterface

// File: rtl/mul_share_arb.sv
// Round-robin arbiter that shares one start/done 8x8 multiplier core among NREQ
// requesters, with a WAIT-state timeout that returns an error result.
module mul_share_arb #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 31
) (
    input  logic           CLK,
    input  logic           RST,
    mul_share_arb_if.slave bus
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  lastGrant_q, lastGrant_d;
    logic [IDW-1:0]  gntId_q, gntId_d;
    logic [7:0]      timer_q, timer_d;
    logic [7:0]      mulA_q, mulA_d;
    logic [7:0]      mulB_q, mulB_d;
    logic [NREQ-1:0] reqAck_q, reqAck_d;
    logic            mulStart_q, mulStart_d;
    logic            resValid_q, resValid_d;
    logic [IDW-1:0]  resId_q, resId_d;
    logic [15:0]     resProduct_q, resProduct_d;
    logic            resErr_q, resErr_d;
    logic            busy_q, busy_d;

    logic            grantFound;
    logic [IDW-1:0]  grantIdx;
    logic [IDW-1:0]  candIdx;

    // Search upward from the requester after the last one served, wrapping at NREQ.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        candIdx    = '0;
        for (int off = 1; off <= NREQ; off++) begin
            candIdx = IDW'((int'(lastGrant_q) + off) % NREQ);
            if (!grantFound && bus.req[candIdx]) begin
                grantFound = 1'b1;
                grantIdx   = candIdx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        lastGrant_d  = lastGrant_q;
        gntId_d      = gntId_q;
        timer_d      = timer_q;
        mulA_d       = mulA_q;
        mulB_d       = mulB_q;
        reqAck_d     = '0;
        mulStart_d   = 1'b0;
        resValid_d   = 1'b0;
        resId_d      = resId_q;
        resProduct_d = resProduct_q;
        resErr_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // Start pulse is registered alongside the ack so it lands in the ISSUE cycle.
                if (grantFound) begin
                    mulA_d     = bus.req_a[8*int'(grantIdx) +: 8];
                    mulB_d     = bus.req_b[8*int'(grantIdx) +: 8];
                    reqAck_d   = NREQ'(1) << grantIdx;
                    mulStart_d = 1'b1;
                    gntId_d    = grantIdx;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + 8'd1;
                if (bus.mul_done) begin
                    resValid_d   = 1'b1;
                    resProduct_d = bus.mul_product;
                    resId_d      = gntId_q;
                    lastGrant_d  = gntId_q;
                    state_d      = IDLE;
                end else if (timer_q == 8'(TIMEOUT - 1)) begin
                    resValid_d   = 1'b1;
                    resErr_d     = 1'b1;
                    resProduct_d = '0;
                    resId_d      = gntId_q;
                    lastGrant_d  = gntId_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            lastGrant_q  <= IDW'(NREQ - 1);
            gntId_q      <= '0;
            timer_q      <= '0;
            mulA_q       <= '0;
            mulB_q       <= '0;
            reqAck_q     <= '0;
            mulStart_q   <= 1'b0;
            resValid_q   <= 1'b0;
            resId_q      <= '0;
            resProduct_q <= '0;
            resErr_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lastGrant_q  <= lastGrant_d;
            gntId_q      <= gntId_d;
            timer_q      <= timer_d;
            mulA_q       <= mulA_d;
            mulB_q       <= mulB_d;
            reqAck_q     <= reqAck_d;
            mulStart_q   <= mulStart_d;
            resValid_q   <= resValid_d;
            resId_q      <= resId_d;
            resProduct_q <= resProduct_d;
            resErr_q     <= resErr_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.req_ack     = reqAck_q;
    assign bus.mul_start   = mulStart_q;
    assign bus.mul_a       = mulA_q;
    assign bus.mul_b       = mulB_q;
    assign bus.res_valid   = resValid_q;
    assign bus.res_id      = resId_q;
    assign bus.res_product = resProduct_q;
    assign bus.res_err     = resErr_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_mul_share_arb.sv
// Bench for mul_share_arb: directed scenarios plus randomized jobs, checked against a
// transaction-level round-robin model and a behavioural multiplier core driven from here.
module tb_mul_share_arb;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 31;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    mul_share_arb_if #(.NREQ(NREQ)) bus ();

    mul_share_arb #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    int              vecCount  = 0;
    int              missCount = 0;
    int              lastGrant;
    logic [NREQ-1:0] pend;
    logic [7:0]      opA [NREQ];
    logic [7:0]      opB [NREQ];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Rotate the pending mask so the slot after the last winner sits at bit 0.
    function automatic int rrPick(input logic [NREQ-1:0] mask, input int last);
        logic [2*NREQ-1:0] twice;
        twice = {mask, mask} >> (last + 1);
        for (int k = 0; k < NREQ; k++)
            if (twice[k]) return (last + 1 + k) % NREQ;
        return -1;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus();
        bus.req = pend;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[8*i +: 8] = opA[i];
            bus.req_b[8*i +: 8] = opB[i];
        end
    endtask

    task automatic applyReset();
        RST          = 1'b1;
        pend         = '0;
        bus.mul_done = 1'b0;
        applyStimulus();
        tick();
        tick();
        RST       = 1'b0;
        lastGrant = NREQ - 1;
        checkOutput("reset.req_ack",     32'(bus.req_ack),     32'd0);
        checkOutput("reset.mul_start",   32'(bus.mul_start),   32'd0);
        checkOutput("reset.res_valid",   32'(bus.res_valid),   32'd0);
        checkOutput("reset.res_err",     32'(bus.res_err),     32'd0);
        checkOutput("reset.mul_a",       32'(bus.mul_a),       32'd0);
        checkOutput("reset.mul_b",       32'(bus.mul_b),       32'd0);
        checkOutput("reset.res_product", 32'(bus.res_product), 32'd0);
        checkOutput("reset.res_id",      32'(bus.res_id),      32'd0);
        checkOutput("reset.busy",        32'(bus.busy),        32'd0);
    endtask

    // Called in an IDLE cycle with the pending mask already driven. lat is the number of
    // cycles after mul_start at which the core pulses done; lat outside 1..TIMEOUT means never.
    task automatic runJob(input int lat, input bit useOvr, input logic [15:0] ovr,
                          input bit rereq, input bit randomStim);
        int          g;
        int          endCycle;
        bit          timeout;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] expP;

        g = rrPick(pend, lastGrant);
        if (g < 0) begin
            checkOutput("job.no_pending", 32'(pend), 32'd1);
            return;
        end
        a        = opA[g];
        b        = opB[g];
        timeout  = !(lat >= 1 && lat <= TIMEOUT);
        endCycle = timeout ? TIMEOUT + 1 : lat + 1;
        expP     = useOvr ? ovr : 16'(int'($signed(a)) * int'($signed(b)));

        tick();
        checkOutput("ack.req_ack",   32'(bus.req_ack),   32'(1) << g);
        checkOutput("ack.mul_start", 32'(bus.mul_start), 32'd1);
        checkOutput("ack.mul_a",     32'(bus.mul_a),     32'(a));
        checkOutput("ack.mul_b",     32'(bus.mul_b),     32'(b));
        checkOutput("ack.busy",      32'(bus.busy),      32'd1);
        pend[g] = rereq;
        applyStimulus();

        for (int c = 1; c <= endCycle; c++) begin
            tick();
            if (c == 1) begin
                checkOutput("wait.req_ack",   32'(bus.req_ack),   32'd0);
                checkOutput("wait.mul_start", 32'(bus.mul_start), 32'd0);
            end
            if (c < endCycle) begin
                checkOutput("wait.res_valid", 32'(bus.res_valid), 32'd0);
                checkOutput("wait.busy",      32'(bus.busy),      32'd1);
                checkOutput("wait.mul_a",     32'(bus.mul_a),     32'(a));
            end else begin
                checkOutput("res.res_valid",   32'(bus.res_valid),   32'd1);
                checkOutput("res.res_id",      32'(bus.res_id),      32'(g));
                checkOutput("res.res_product", 32'(bus.res_product), timeout ? 32'd0 : 32'(expP));
                checkOutput("res.res_err",     32'(bus.res_err),     32'(timeout));
                checkOutput("res.busy",        32'(bus.busy),        32'd0);
            end
            bus.mul_done    = (!timeout && c == lat);
            bus.mul_product = bus.mul_done ? expP : 16'($urandom);
            if (randomStim) begin
                for (int i = 0; i < NREQ; i++) begin
                    opA[i] = 8'($urandom);
                    opB[i] = 8'($urandom);
                end
                if ($urandom_range(0, 3) == 0) pend = NREQ'($urandom);
            end
            applyStimulus();
        end
        lastGrant = g;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            opA[i] = '0;
            opB[i] = '0;
        end
        bus.mul_product = '0;
        applyReset();

        // Single job from requester 1: -3 * 5.
        opA[1] = 8'hFD;
        opB[1] = 8'h05;
        pend   = 4'b0010;
        applyStimulus();
        runJob(10, 1'b0, 16'h0, 1'b0, 1'b0);

        // Everyone at once: grants sweep 0..3.
        applyReset();
        for (int i = 0; i < NREQ; i++) begin
            opA[i] = 8'(i + 1);
            opB[i] = 8'h02;
        end
        pend = 4'b1111;
        applyStimulus();
        for (int j = 0; j < NREQ; j++) runJob(3 + j, 1'b0, 16'h0, 1'b0, 1'b0);

        // Fairness after a job from requester 2, with requester 3 re-requesting.
        applyReset();
        pend = 4'b0100;
        applyStimulus();
        runJob(4, 1'b0, 16'h0, 1'b0, 1'b0);
        pend = 4'b1001;
        applyStimulus();
        runJob(5, 1'b0, 16'h0, 1'b1, 1'b0);
        runJob(6, 1'b0, 16'h0, 1'b0, 1'b0);
        runJob(2, 1'b0, 16'h0, 1'b0, 1'b0);

        // Core never answers, then a normal job.
        pend = 4'b0001;
        applyStimulus();
        runJob(0, 1'b0, 16'h0, 1'b0, 1'b0);
        pend = 4'b0100;
        applyStimulus();
        runJob(7, 1'b0, 16'h0, 1'b0, 1'b0);

        // Reset three cycles into WAIT, then a stale done.
        applyReset();
        opA[1] = 8'h11;
        opB[1] = 8'h22;
        pend   = 4'b0010;
        applyStimulus();
        tick();
        checkOutput("rst.req_ack", 32'(bus.req_ack), 32'b0010);
        pend = '0;
        applyStimulus();
        repeat (3) tick();
        RST = 1'b1;
        tick();
        RST       = 1'b0;
        lastGrant = NREQ - 1;
        checkOutput("rst.mul_a",     32'(bus.mul_a),     32'd0);
        checkOutput("rst.res_valid", 32'(bus.res_valid), 32'd0);
        checkOutput("rst.busy",      32'(bus.busy),      32'd0);
        bus.mul_done    = 1'b1;
        bus.mul_product = 16'h1234;
        tick();
        bus.mul_done = 1'b0;
        checkOutput("stale.res_valid",   32'(bus.res_valid),   32'd0);
        checkOutput("stale.res_product", 32'(bus.res_product), 32'd0);
        checkOutput("stale.busy",        32'(bus.busy),        32'd0);
        pend = 4'b0011;
        applyStimulus();
        runJob(3, 1'b0, 16'h0, 1'b0, 1'b0);
        runJob(3, 1'b0, 16'h0, 1'b0, 1'b0);

        // Done lands on the final timeout cycle; the core's product wins.
        opA[2] = 8'h7F;
        opB[2] = 8'h7F;
        pend   = 4'b0100;
        applyStimulus();
        runJob(TIMEOUT, 1'b1, 16'h7F01, 1'b0, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            if (pend == '0) begin
                pend = NREQ'($urandom_range(1, (1 << NREQ) - 1));
                applyStimulus();
            end
            runJob(int'($urandom_range(1, TIMEOUT + 3)), 1'b0, 16'h0,
                   1'($urandom_range(0, 1)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule
